// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle FETCH/EXEC/WB sequencer for the single-cycle
// register/ALU datapath. It owns the PC and fetches 32-bit instructions over
// a req/ack handshake with a bounded wait. It holds each instruction for one
// settle cycle, then strobes the register-file write enable.
//
// Optional feature: define INSTR_SEQ_RETIRE_CNT_EN to add the retired_o
// counter port. Without the macro the port and its counter do not exist.
module instr_sequencer #(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_pc_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_rdata_i,
  output logic [31:0]       instruction_o,
  output logic              write_ena_o,
  output logic              busy_o,
  output logic              halted_o,
  output logic [1:0]        error_o
`ifdef INSTR_SEQ_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]  retired_o
`endif
);

  localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [31:0]       ECALL     = 32'h0000_0073;
  localparam logic [6:0]        OP_IMM    = 7'b0010011;
  localparam logic [6:0]        OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_WB, S_HALT, S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [31:0]         r_instr;
  logic [WAIT_W-1:0]   r_wait;
  err_t                r_error;

  logic                w_is_ecall;
  logic                w_is_alu;
  logic                w_wait_expired;
  logic                w_load_start;
  logic                w_accept;
  logic                w_illegal;
  logic                w_timeout;
  logic                w_advance;

  // Decode the word on the read bus. It is only consumed when an ack is taken.
  always_comb begin
    w_is_ecall     = (imem_rdata_i == ECALL);
    w_is_alu       = (imem_rdata_i[6:0] == OP_IMM) || (imem_rdata_i[6:0] == OP_REG);
    w_wait_expired = (r_wait == WAIT_LAST);
  end

  // State register. Reset is synchronous and overrides start_i.
  always_ff @(posedge clock_i) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state decode plus Moore/Mealy outputs and register-update strobes.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    w_next_state = r_state;
    imem_req_o   = 1'b0;
    write_ena_o  = 1'b0;
    busy_o       = 1'b0;
    halted_o     = 1'b0;
    w_load_start = 1'b0;
    w_accept     = 1'b0;
    w_illegal    = 1'b0;
    w_timeout    = 1'b0;
    w_advance    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_load_start = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_req_o = 1'b1;
        busy_o     = 1'b1;
        if (imem_ack_i) begin
          w_accept = 1'b1;
          if (w_is_ecall)    w_next_state = S_HALT;
          else if (w_is_alu) w_next_state = S_EXEC;
          else begin
            w_illegal    = 1'b1;
            w_next_state = S_ERROR;
          end
        end else if (w_wait_expired) begin
          w_timeout    = 1'b1;
          w_next_state = S_ERROR;
        end
      end
      S_EXEC: begin
        busy_o       = 1'b1;
        w_next_state = S_WB;
      end
      S_WB: begin
        busy_o       = 1'b1;
        // Writes to x0 are architecturally discarded, so the strobe is masked.
        write_ena_o  = (r_instr[11:7] != 5'd0);
        w_advance    = 1'b1;
        w_next_state = S_FETCH;
      end
      S_HALT: begin
        halted_o = 1'b1;
        if (start_i) begin
          w_load_start = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_ERROR: begin
        // Sticky until reset; start_i has no effect here.
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // PC, instruction register, ack wait counter and error cause.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_pc    <= '0;
      r_instr <= '0;
      r_wait  <= '0;
      r_error <= ERR_NONE;
    end else begin
      if (w_load_start)   r_pc <= start_pc_i;
      else if (w_advance) r_pc <= r_pc + ADDR_W'(4);

      if (w_accept) r_instr <= imem_rdata_i;

      // Counts FETCH cycles without ack; cleared on ack, timeout or leaving FETCH.
      if (r_state == S_FETCH && !imem_ack_i && !w_wait_expired)
        r_wait <= r_wait + WAIT_W'(1);
      else
        r_wait <= '0;

      if (w_illegal)      r_error <= ERR_ILLEGAL;
      else if (w_timeout) r_error <= ERR_TIMEOUT;
    end
  end

`ifdef INSTR_SEQ_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_retired;

  // Retired count: one per WB visit (rd = x0 included), cleared only by reset.
  always_ff @(posedge clock_i) begin
    if (reset_i)              r_retired <= '0;
    else if (r_state == S_WB) r_retired <= r_retired + CNT_W'(1);
  end

  assign retired_o = r_retired;
`endif

  assign imem_addr_o   = r_pc;
  assign instruction_o = r_instr;
  assign error_o       = r_error;

endmodule
